// File: rtl/slot_pkg.sv
// Shared types and sizes for the three-reel slot machine.
// Holds the game state encoding and the reel/credit/step widths.
package slot_pkg;

    localparam int REEL_W     = 4;
    localparam int NUM_REELS  = 3;
    localparam int CREDIT_W   = 8;
    localparam int CREDIT_MAX = 255;
    localparam int STEP_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SPIN = 2'b01,
        ST_EVAL = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Player/display bundle of the slot game sequencer.
// master drives the controls, slave is the sequencer.
interface slot_game_ctrl_if;
    import slot_pkg::*;

    logic                          TICK;
    logic                          START;
    logic                          COIN;
    logic [NUM_REELS*REEL_W-1:0]   RAND;
    logic [REEL_W-1:0]             REEL0;
    logic [REEL_W-1:0]             REEL1;
    logic [REEL_W-1:0]             REEL2;
    logic [NUM_REELS-1:0]          REEL_RUN;
    logic [1:0]                    STATE;
    logic                          WIN;
    logic                          JACKPOT;
    logic [CREDIT_W-1:0]           CREDITS;

    modport master (
        output TICK, START, COIN, RAND,
        input  REEL0, REEL1, REEL2, REEL_RUN,
        input  STATE, WIN, JACKPOT, CREDITS
    );

    modport slave (
        input  TICK, START, COIN, RAND,
        output REEL0, REEL1, REEL2, REEL_RUN,
        output STATE, WIN, JACKPOT, CREDITS
    );

endinterface

// File: rtl/slot_reel.sv
// One reel: 4-bit position counter, latched stop target and run flag.
// Stops on the step where it lands on target after its minimum count.
module slot_reel
    import slot_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              load,
    input  logic              tick,
    input  logic [REEL_W-1:0] target_in,
    input  logic [STEP_W-1:0] step_count,
    input  logic [STEP_W-1:0] min_steps,
    output logic [REEL_W-1:0] value,
    output logic              running
);

    logic [REEL_W-1:0] target;
    logic [REEL_W-1:0] value_nxt;

    assign value_nxt = value + 1'b1;

    // latch target on load, step while running, stop on target past minimum
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            value   <= '0;
            target  <= '0;
            running <= 1'b0;
        end else if (load) begin
            target  <= target_in;
            running <= 1'b1;
        end else if (tick && running) begin
            value <= value_nxt;
            if (value_nxt == target && step_count >= min_steps)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot game sequencer: charge, spin, stop, score, pay, hold.
// Define SLOT_FREE_PLAY_EN to start games without spending credits.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int MIN_STEPS  = 16,
    parameter int STAGGER    = 8,
    parameter int HOLD_TICKS = 5,
    parameter int PAY2       = 2,
    parameter int PAY3       = 10
) (
    input logic             CLK,
    input logic             CLR_N,
    slot_game_ctrl_if.slave bus
);

    localparam int SUM_W = CREDIT_W + 2;

    state_t              state, state_nxt;
    logic                start_q, start_edge;
    logic                accept, do_eval, can_play, spend, spin_tick;
    logic [STEP_W-1:0]   step_cnt, step_nxt, hold_cnt;
    logic [CREDIT_W-1:0] credits, pay;
    logic [SUM_W-1:0]    csum;
    logic                win, jackpot, all3, two;
    logic [REEL_W-1:0]   val [NUM_REELS];
    logic [NUM_REELS-1:0] run;

    assign start_edge = bus.START & ~start_q;
    assign spin_tick  = bus.TICK && state == ST_SPIN;
    assign step_nxt   = step_cnt + 1'b1;

`ifdef SLOT_FREE_PLAY_EN
    assign can_play = 1'b1;
    assign spend    = 1'b0;
`else
    assign can_play = credits != '0;
    assign spend    = accept;
`endif

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        slot_reel u_reel (
            .CLK        (CLK),
            .CLR_N      (CLR_N),
            .load       (accept),
            .tick       (spin_tick),
            .target_in  (bus.RAND[i*REEL_W +: REEL_W]),
            .step_count (step_nxt),
            .min_steps  (STEP_W'(MIN_STEPS + i*STAGGER)),
            .value      (val[i]),
            .running    (run[i])
        );
    end

    assign all3 = val[0] == val[1] && val[1] == val[2];
    assign two  = !all3 && (val[0] == val[1] ||
                            val[1] == val[2] ||
                            val[0] == val[2]);

    // next state and one-cycle game events
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_eval   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_edge && can_play) begin
                    accept    = 1'b1;
                    state_nxt = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (run == '0)
                    state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                do_eval   = 1'b1;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.TICK && hold_cnt == STEP_W'(HOLD_TICKS - 1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // payout and saturating credit sum
    always_comb begin
        pay = '0;
        if (do_eval) begin
            unique case (1'b1)
                all3:    pay = CREDIT_W'(PAY3);
                two:     pay = CREDIT_W'(PAY2);
                default: pay = '0;
            endcase
        end
        csum = SUM_W'(credits) + SUM_W'(bus.COIN)
             + SUM_W'(pay) - SUM_W'(spend);
    end

    // state register and start edge history
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.START;
        end
    end

    // step and hold tick counters
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (accept)
                step_cnt <= '0;
            else if (spin_tick)
                step_cnt <= step_nxt;
            if (state != ST_HOLD)
                hold_cnt <= '0;
            else if (bus.TICK)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // credit balance and result flags
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            credits <= '0;
            win     <= 1'b0;
            jackpot <= 1'b0;
        end else begin
            if (csum > SUM_W'(CREDIT_MAX))
                credits <= CREDIT_W'(CREDIT_MAX);
            else
                credits <= csum[CREDIT_W-1:0];
            if (accept) begin
                win     <= 1'b0;
                jackpot <= 1'b0;
            end else if (do_eval) begin
                win     <= two;
                jackpot <= all3;
            end
        end
    end

    assign bus.REEL0    = val[0];
    assign bus.REEL1    = val[1];
    assign bus.REEL2    = val[2];
    assign bus.REEL_RUN = run;
    assign bus.STATE    = state;
    assign bus.WIN      = win;
    assign bus.JACKPOT  = jackpot;
    assign bus.CREDITS  = credits;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: directed scenarios plus random games
// checked against a stop-tick/payout reference model.
module tb_slot_game_ctrl;
    import slot_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slot_game_ctrl_if bus ();

    slot_game_ctrl dut (
        .CLK   (clk),
        .CLR_N (rst_n),
        .bus   (bus)
    );

`ifdef SLOT_FREE_PLAY_EN
    localparam int SPEND = 0;
`else
    localparam int SPEND = 1;
`endif

    int errors = 0;
    int checks = 0;
    int m_credits = 0;
    int m_reel [3] = '{0, 0, 0};

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int tgt(input logic [11:0] r, input int i);
        logic [11:0] rr;
        rr = r >> (4 * i);
        return int'(rr[3:0]);
    endfunction

    // first tick at/after the reel's minimum that lands on the target
    function automatic int exp_stop(input int v0, input int t, input int i);
        for (int n = 1; n < 200; n++)
            if ((v0 + n) % 16 == t && n >= 16 + 8 * i) return n;
        return -1;
    endfunction

    function automatic int pay_of(input logic [11:0] r);
        int a, b, c;
        a = tgt(r, 0); b = tgt(r, 1); c = tgt(r, 2);
        if (a == b && b == c) return 10;
        if (a == b || b == c || a == c) return 2;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_pulse();
        bus.COIN = 1'b1;
        step();
        bus.COIN = 1'b0;
        m_credits = sat(m_credits + 1);
    endtask

    task automatic start_game(input logic [11:0] r);
        bus.RAND = r;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    task automatic spin_game(input bit poke, input bit coin_eval,
                             output int stop [3], output bit tmo);
        int t;
        stop = '{0, 0, 0};
        tmo = 1'b0;
        t = 0;
        while (bus.REEL_RUN != 3'b000 && !tmo) begin
            step();
            if (poke) bus.START = ~bus.START;
            bus.TICK = 1'b1;
            step();
            bus.TICK = 1'b0;
            t++;
            for (int i = 0; i < 3; i++)
                if (stop[i] == 0 && !bus.REEL_RUN[i]) stop[i] = t;
            if (t > 200) tmo = 1'b1;
        end
        bus.START = 1'b0;
        step();
        if (coin_eval) bus.COIN = 1'b1;
        step();
        bus.COIN = 1'b0;
    endtask

    task automatic hold_ticks(input int n);
        repeat (n) begin
            bus.TICK = 1'b1;
            step();
            bus.TICK = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_credits = 0;
        m_reel = '{0, 0, 0};
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if (bus.STATE !== 2'b00 || bus.CREDITS !== 8'd0 ||
            bus.REEL_RUN !== 3'b000) begin
            errors++;
            $display("FAIL reset_init: st=%0d cr=%0d run=%b required 0/0/000",
                     bus.STATE, bus.CREDITS, bus.REEL_RUN);
        end
        rst_n = 1'b1;
        step();
        coin_pulse();
        start_game(12'h777);
        hold_ticks(10);
        checks++;
        if (bus.STATE !== 2'b01 || bus.REEL0 !== 4'd10) begin
            errors++;
            $display("FAIL reset_prespin: st=%0d reel0=%0d required 1/10",
                     bus.STATE, bus.REEL0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.STATE !== 2'b00 || bus.REEL0 !== 4'd0 ||
            bus.REEL1 !== 4'd0 || bus.REEL2 !== 4'd0 ||
            bus.REEL_RUN !== 3'b000 || bus.WIN !== 1'b0 ||
            bus.JACKPOT !== 1'b0 || bus.CREDITS !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: st=%0d r=%0d/%0d/%0d run=%b cr=%0d required all 0",
                     bus.STATE, bus.REEL0, bus.REEL1, bus.REEL2,
                     bus.REEL_RUN, bus.CREDITS);
        end
        step();
        do_reset();
    endtask

    task automatic test_no_credit();
        start_game(12'h456);
        step();
        checks++;
`ifdef SLOT_FREE_PLAY_EN
        if (bus.STATE !== 2'b01 || bus.REEL_RUN !== 3'b111 ||
            bus.CREDITS !== 8'd0) begin
            errors++;
            $display("FAIL no_credit: st=%0d run=%b cr=%0d required 1/111/0",
                     bus.STATE, bus.REEL_RUN, bus.CREDITS);
        end
        do_reset();
`else
        if (bus.STATE !== 2'b00 || bus.REEL_RUN !== 3'b000 ||
            bus.CREDITS !== 8'd0) begin
            errors++;
            $display("FAIL no_credit: st=%0d run=%b cr=%0d required 0/000/0",
                     bus.STATE, bus.REEL_RUN, bus.CREDITS);
        end
`endif
    endtask

    task automatic test_jackpot();
        int stop [3];
        int want [3];
        bit tmo;
        want = '{23, 39, 39};
        repeat (3) coin_pulse();
        start_game(12'h777);
        m_credits -= SPEND;
        checks++;
        if (bus.CREDITS !== 8'(m_credits) || bus.STATE !== 2'b01 ||
            bus.REEL_RUN !== 3'b111) begin
            errors++;
            $display("FAIL jp_start: cr=%0d st=%0d run=%b required %0d/1/111",
                     bus.CREDITS, bus.STATE, bus.REEL_RUN, m_credits);
        end
        spin_game(1'b0, 1'b0, stop, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL jp_timeout: reels still running required stopped");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stop[i] != want[i]) begin
                errors++;
                $display("FAIL jp_stop%0d: tick %0d required %0d",
                         i, stop[i], want[i]);
            end
        end
        m_credits = sat(m_credits + 10);
        m_reel = '{7, 7, 7};
        checks++;
        if (bus.STATE !== 2'b11 || bus.JACKPOT !== 1'b1 ||
            bus.WIN !== 1'b0 || bus.CREDITS !== 8'(m_credits) ||
            bus.REEL0 !== 4'd7 || bus.REEL2 !== 4'd7) begin
            errors++;
            $display("FAIL jp_result: st=%0d jp=%b win=%b cr=%0d r0=%0d required 3/1/0/%0d/7",
                     bus.STATE, bus.JACKPOT, bus.WIN, bus.CREDITS,
                     bus.REEL0, m_credits);
        end
        hold_ticks(5);
    endtask

    task automatic test_win_none();
        logic [11:0] rs [2];
        int stop [3];
        bit tmo;
        int p;
        rs = '{12'h335, 12'h123};
        foreach (rs[k]) begin
            start_game(rs[k]);
            m_credits -= SPEND;
            spin_game(1'b0, 1'b0, stop, tmo);
            p = pay_of(rs[k]);
            m_credits = sat(m_credits + p);
            for (int i = 0; i < 3; i++) m_reel[i] = tgt(rs[k], i);
            checks++;
            if (tmo || bus.WIN !== (p == 2) || bus.JACKPOT !== 1'b0 ||
                bus.CREDITS !== 8'(m_credits)) begin
                errors++;
                $display("FAIL win_none %h: tmo=%b win=%b jp=%b cr=%0d required win=%b cr=%0d",
                         rs[k], tmo, bus.WIN, bus.JACKPOT, bus.CREDITS,
                         p == 2, m_credits);
            end
            hold_ticks(5);
        end
    endtask

    task automatic test_saturate();
        int stop [3];
        bit tmo;
        while (m_credits < 250) coin_pulse();
        checks++;
        if (bus.CREDITS !== 8'd250) begin
            errors++;
            $display("FAIL sat_fill: cr=%0d required 250", bus.CREDITS);
        end
        start_game(12'hAAA);
        m_credits -= SPEND;
        spin_game(1'b0, 1'b1, stop, tmo);
        m_credits = sat(m_credits + 10 + 1);
        m_reel = '{10, 10, 10};
        checks++;
        if (tmo || bus.JACKPOT !== 1'b1 || bus.CREDITS !== 8'd255) begin
            errors++;
            $display("FAIL sat_payout: tmo=%b jp=%b cr=%0d required 1/255",
                     tmo, bus.JACKPOT, bus.CREDITS);
        end
        hold_ticks(5);
        coin_pulse();
        checks++;
        if (bus.CREDITS !== 8'd255) begin
            errors++;
            $display("FAIL sat_coin: cr=%0d required 255", bus.CREDITS);
        end
    endtask

    task automatic test_ignore_edges();
        int stop [3];
        bit tmo;
        logic [11:0] r;
        r = 12'(($urandom & 32'hFFF));
        start_game(r);
        m_credits -= SPEND;
        spin_game(1'b1, 1'b0, stop, tmo);
        m_credits = sat(m_credits + pay_of(r));
        for (int i = 0; i < 3; i++) m_reel[i] = tgt(r, i);
        checks++;
        if (tmo || bus.STATE !== 2'b11 ||
            bus.CREDITS !== 8'(m_credits)) begin
            errors++;
            $display("FAIL ign_spin: tmo=%b st=%0d cr=%0d required 3/%0d",
                     tmo, bus.STATE, bus.CREDITS, m_credits);
        end
        repeat (4) begin
            bus.START = ~bus.START;
            hold_ticks(1);
        end
        checks++;
        if (bus.STATE !== 2'b11) begin
            errors++;
            $display("FAIL hold_4: st=%0d required 3", bus.STATE);
        end
        bus.START = 1'b1;
        hold_ticks(1);
        checks++;
        if (bus.STATE !== 2'b00) begin
            errors++;
            $display("FAIL hold_5: st=%0d required 0", bus.STATE);
        end
        repeat (3) step();
        checks++;
        if (bus.STATE !== 2'b00 || bus.REEL_RUN !== 3'b000 ||
            bus.CREDITS !== 8'(m_credits)) begin
            errors++;
            $display("FAIL held_start: st=%0d run=%b cr=%0d required 0/000/%0d",
                     bus.STATE, bus.REEL_RUN, bus.CREDITS, m_credits);
        end
        bus.START = 1'b0;
        step();
        r = 12'h9C4;
        start_game(r);
        m_credits -= SPEND;
        checks++;
        if (bus.STATE !== 2'b01 || bus.CREDITS !== 8'(m_credits)) begin
            errors++;
            $display("FAIL new_edge: st=%0d cr=%0d required 1/%0d",
                     bus.STATE, bus.CREDITS, m_credits);
        end
        spin_game(1'b0, 1'b0, stop, tmo);
        m_credits = sat(m_credits + pay_of(r));
        for (int i = 0; i < 3; i++) m_reel[i] = tgt(r, i);
        hold_ticks(5);
    endtask

    task automatic test_random();
        int stop [3];
        int want [3];
        bit tmo;
        logic [11:0] r;
        int p;
        for (int g = 0; g < 8; g++) begin
            repeat ($urandom_range(0, 2)) coin_pulse();
            if (m_credits == 0) coin_pulse();
            r = 12'(($urandom & 32'hFFF));
            for (int i = 0; i < 3; i++)
                want[i] = exp_stop(m_reel[i], tgt(r, i), i);
            start_game(r);
            m_credits -= SPEND;
            spin_game(1'b0, 1'b0, stop, tmo);
            p = pay_of(r);
            m_credits = sat(m_credits + p);
            for (int i = 0; i < 3; i++) m_reel[i] = tgt(r, i);
            checks++;
            if (tmo || stop[0] != want[0] || stop[1] != want[1] ||
                stop[2] != want[2]) begin
                errors++;
                $display("FAIL rnd_stop %h: got %0d/%0d/%0d required %0d/%0d/%0d",
                         r, stop[0], stop[1], stop[2],
                         want[0], want[1], want[2]);
            end
            checks++;
            if (bus.WIN !== (p == 2) || bus.JACKPOT !== (p == 10) ||
                bus.CREDITS !== 8'(m_credits) ||
                bus.REEL0 !== 4'(m_reel[0]) ||
                bus.REEL1 !== 4'(m_reel[1]) ||
                bus.REEL2 !== 4'(m_reel[2])) begin
                errors++;
                $display("FAIL rnd_result %h: win=%b jp=%b cr=%0d required %b/%b/%0d",
                         r, bus.WIN, bus.JACKPOT, bus.CREDITS,
                         p == 2, p == 10, m_credits);
            end
            hold_ticks(5);
            checks++;
            if (bus.STATE !== 2'b00) begin
                errors++;
                $display("FAIL rnd_idle: st=%0d required 0", bus.STATE);
            end
        end
    endtask

    initial begin
        bus.TICK = 1'b0;
        bus.START = 1'b0;
        bus.COIN = 1'b0;
        bus.RAND = '0;
        test_reset();
        test_no_credit();
        test_jackpot();
        test_win_none();
        test_saturate();
        test_ignore_edges();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
